// File: rtl/instr_word_encoder_pkg.sv
// Purpose : shared RV32I encoding constants for the program loader.
//           Holds opcodes, micro-op class codes, ALU-op codes, the loader
//           FSM state type and the funct3 lookup shared by every user.
// Ports   : none (package).
package instr_word_encoder_pkg;

  // Major opcodes
  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_B   = 7'b1100011;

  // Micro-op classes
  localparam logic [1:0] CLS_R = 2'b00;
  localparam logic [1:0] CLS_I = 2'b01;
  localparam logic [1:0] CLS_U = 2'b10;
  localparam logic [1:0] CLS_B = 2'b11;

  // ALU operation codes (same numbering as the ALU control decode)
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_OR  = 4'd2;
  localparam logic [3:0] OP_SLL = 4'd3;
  localparam logic [3:0] OP_SRL = 4'd4;
  localparam logic [3:0] OP_LUI = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_BEQ = 4'd8;
  localparam logic [3:0] OP_BNE = 4'd9;
  localparam logic [3:0] OP_BLT = 4'd10;
  localparam logic [3:0] OP_BGE = 4'd11;

  localparam logic [6:0] F7_SUB = 7'b0100000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // funct3 field for an ALU/branch op; ops without a funct3 return 000
  function automatic logic [2:0] funct3_of(input logic [3:0] op);
    logic [2:0] f3;
    case (op)
      OP_ADD, OP_SUB: f3 = 3'b000;
      OP_SLL:         f3 = 3'b001;
      OP_XOR:         f3 = 3'b100;
      OP_SRL:         f3 = 3'b101;
      OP_OR:          f3 = 3'b110;
      OP_AND:         f3 = 3'b111;
      OP_BEQ:         f3 = 3'b000;
      OP_BNE:         f3 = 3'b001;
      OP_BLT:         f3 = 3'b100;
      OP_BGE:         f3 = 3'b101;
      default:        f3 = 3'b000;
    endcase
    return f3;
  endfunction

endpackage

// File: rtl/instr_word_encoder_encode_core.sv
// Purpose : combinational micro-op to RV32I word encoder.
// Ports   : cls_i/op_i/rd_i/rs1_i/rs2_i/imm_i  micro-op fields
//           word_o     encoded instruction (0 when illegal)
//           illegal_o  class/op pair has no encoding
module instr_encode_core
  import instr_word_encoder_pkg::*;
(
  input  logic [1:0]  cls_i,
  input  logic [3:0]  op_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [19:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  logic [2:0] w_f3;
  logic       w_shift;
  logic       w_i_ok;
  logic       w_r_ok;
  logic       w_b_ok;

  // Encode the micro-op and flag class/op pairs with no legal encoding
  always_comb begin
    w_f3      = funct3_of(op_i);
    w_shift   = (op_i == OP_SLL) | (op_i == OP_SRL);
    w_i_ok    = (op_i == OP_ADD) | (op_i == OP_OR) | w_shift |
                (op_i == OP_AND) | (op_i == OP_XOR);
    w_r_ok    = w_i_ok | (op_i == OP_SUB);
    w_b_ok    = (op_i == OP_BEQ) | (op_i == OP_BNE) |
                (op_i == OP_BLT) | (op_i == OP_BGE);
    word_o    = 32'd0;
    illegal_o = 1'b0;
    case (cls_i)
      CLS_R: begin
        if (w_r_ok) begin
          word_o = {((op_i == OP_SUB) ? F7_SUB : 7'b0000000),
                    rs2_i, rs1_i, w_f3, rd_i, OPC_R};
        end else begin
          illegal_o = 1'b1;
        end
      end
      CLS_I: begin
        if (w_i_ok & w_shift) begin
          // shift amount only; upper immediate bits forced to zero
          word_o = {7'b0000000, imm_i[4:0], rs1_i, w_f3, rd_i, OPC_I};
        end else if (w_i_ok) begin
          word_o = {imm_i[11:0], rs1_i, w_f3, rd_i, OPC_I};
        end else begin
          illegal_o = 1'b1;
        end
      end
      CLS_U: begin
        if (op_i == OP_LUI) begin
          word_o = {imm_i[19:0], rd_i, OPC_LUI};
        end else begin
          illegal_o = 1'b1;
        end
      end
      CLS_B: begin
        if (w_b_ok) begin
          word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, w_f3,
                    imm_i[4:1], imm_i[11], OPC_B};
        end else begin
          illegal_o = 1'b1;
        end
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_word_encoder.sv
// Purpose : on-chip program loader. Encodes count_i legal micro-ops into
//           RV32I words, buffers them in a small FIFO and writes them to
//           consecutive word addresses starting at base_addr_i.
// Ports   : clk, reset (sync, active-low)
//           start_i/base_addr_i/count_i     load request
//           in_valid_i/in_ready_o + fields  micro-op stream
//           mem_we_o/mem_ready_i/mem_addr_o/mem_wdata_o  memory write port
//           busy_o, done_o (1-cycle pulse), err_o (sticky illegal-op flag)
module instr_word_encoder
  import instr_word_encoder_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [CNT_W-1:0]  count_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [1:0]        class_i,
  input  logic [3:0]        alu_op_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [19:0]       imm_i,
  output logic              mem_we_o,
  input  logic              mem_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_acc;
  logic              r_err;
  logic              r_done;
  logic [31:0]       r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [PTR_W:0]    r_fcnt;

  logic [31:0]       w_word;
  logic              w_illegal;
  logic              w_in_ready;
  logic              w_start_take;
  logic              w_full;
  logic              w_empty;
  logic              w_hs;
  logic              w_push;
  logic              w_drop;
  logic              w_pop;

  instr_encode_core u_core (
    .cls_i     (class_i),
    .op_i      (alu_op_i),
    .rd_i      (rd_i),
    .rs1_i     (rs1_i),
    .rs2_i     (rs2_i),
    .imm_i     (imm_i),
    .word_o    (w_word),
    .illegal_o (w_illegal)
  );

  assign w_full  = (r_fcnt == (PTR_W + 1)'(FIFO_DEPTH));
  assign w_empty = (r_fcnt == '0);
  assign w_hs    = in_valid_i & w_in_ready;
  assign w_push  = w_hs & ~w_illegal;
  assign w_drop  = w_hs & w_illegal;
  assign w_pop   = ~w_empty & mem_ready_i;

  // Next-state and handshake decode for the load FSM
  always_comb begin
    w_state_nxt  = r_state;
    w_in_ready   = 1'b0;
    w_start_take = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_start_take = 1'b1;
          w_state_nxt  = (count_i == '0) ? ST_DONE : ST_RUN;
        end else begin
          w_state_nxt  = ST_IDLE;
        end
      end
      ST_RUN: begin
        w_in_ready = ~w_full & (r_acc < r_cnt);
        if (r_acc == r_cnt) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // an empty FIFO means no write is outstanding
        if (w_empty) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register and registered done pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == ST_DONE);
    end
  end

  // Load parameters, accepted-op counter, write address and sticky error
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_addr <= '0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_err  <= 1'b0;
    end else if (w_start_take) begin
      r_addr <= base_addr_i;
      r_cnt  <= count_i;
      r_acc  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_pop) begin
        r_addr <= r_addr + ADDR_W'(4);
      end
      if (w_push) begin
        r_acc <= r_acc + CNT_W'(1);
      end
      if (w_drop) begin
        r_err <= 1'b1;
      end
    end
  end

  // Encoded-word FIFO; push and pop may happen in the same cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo[i] <= 32'd0;
      end
      r_wptr <= '0;
      r_rptr <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= w_word;
        r_wptr         <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + (PTR_W + 1)'(1);
        2'b01:   r_fcnt <= r_fcnt - (PTR_W + 1)'(1);
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

  assign in_ready_o  = w_in_ready;
  assign mem_we_o    = ~w_empty;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_fifo[r_rptr];
  assign busy_o      = (r_state != ST_IDLE);
  assign done_o      = r_done;
  assign err_o       = r_err;

endmodule

// File: tb/tb_instr_word_encoder.sv
module tb_instr_word_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [31:0] base_addr_i;
  logic [7:0]  count_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [1:0]  class_i;
  logic [3:0]  alu_op_i;
  logic [4:0]  rd_i, rs1_i, rs2_i;
  logic [19:0] imm_i;
  logic        mem_we_o;
  logic        mem_ready_i;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        busy_o, done_o, err_o;

  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;
  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];

  instr_word_encoder dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .count_i     (count_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .class_i     (class_i),
    .alu_op_i    (alu_op_i),
    .rd_i        (rd_i),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .imm_i       (imm_i),
    .mem_we_o    (mem_we_o),
    .mem_ready_i (mem_ready_i),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  // capture every completed memory write and every done pulse
  always @(posedge clk) begin
    if (mem_we_o && mem_ready_i) begin
      q_addr.push_back(mem_addr_o);
      q_data.push_back(mem_wdata_o);
    end
    if (done_o) n_done++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] base, input logic [7:0] cnt);
    start_i     = 1'b1;
    base_addr_i = base;
    count_i     = cnt;
    tick();
    start_i     = 1'b0;
  endtask

  task automatic send_op(input logic [1:0] c, input logic [3:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [19:0] imm);
    bit ok = 0;
    class_i = c; alu_op_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2; imm_i = imm;
    in_valid_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (in_ready_o) begin
        ok = 1;
        tick();
        break;
      end
      tick();
    end
    in_valid_i = 1'b0;
    n_checks++;
    if (!ok) $display("FAIL send_op timeout: in_ready_o never high (op %0h), required accept within 50 cycles", op);
    else n_pass++;
  endtask

  task automatic wait_done(input string name);
    int start_done = n_done;
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (n_done > start_done) begin
        ok = 1;
        break;
      end
      tick();
    end
    n_checks++;
    if (!ok) $display("FAIL %s done timeout: done_o pulses %0d, required 1", name, n_done - start_done);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    n_checks++;
    if ({mem_we_o, in_ready_o, busy_o, done_o, err_o} !== 5'b0)
      $display("FAIL reset_flags: got %b, required 00000", {mem_we_o, in_ready_o, busy_o, done_o, err_o});
    else n_pass++;
    n_checks++;
    if ({mem_addr_o, mem_wdata_o} !== 64'd0)
      $display("FAIL reset_bus: addr %h data %h, required 0/0", mem_addr_o, mem_wdata_o);
    else n_pass++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_add();
    q_addr.delete(); q_data.delete();
    do_start(32'h0040_0000, 8'd1);
    n_checks++;
    if (busy_o !== 1'b1) $display("FAIL busy_after_start: got %b, required 1", busy_o);
    else n_pass++;
    send_op(2'b00, 4'd0, 5'd3, 5'd1, 5'd2, 20'd0);
    wait_done("single");
    n_checks++;
    if (q_addr.size() != 1 || q_addr[0] !== 32'h0040_0000 || q_data[0] !== 32'h002081B3)
      $display("FAIL single_add: %0d writes, first %h @%h, required 1 write 002081b3 @00400000",
               q_addr.size(), (q_data.size() > 0) ? q_data[0] : 32'hx, (q_addr.size() > 0) ? q_addr[0] : 32'hx);
    else n_pass++;
    n_checks++;
    if ({busy_o, err_o} !== 2'b00) $display("FAIL single_idle: busy/err %b, required 00", {busy_o, err_o});
    else n_pass++;
  endtask

  task automatic test_five();
    logic [31:0] exp_d [5] = '{32'h002081B3, 32'h407302B3, 32'hFFF00093, 32'h12345537, 32'h00208463};
    q_addr.delete(); q_data.delete();
    do_start(32'h0000_1000, 8'd5);
    send_op(2'b00, 4'd0, 5'd3,  5'd1, 5'd2, 20'd0);
    send_op(2'b00, 4'd1, 5'd5,  5'd6, 5'd7, 20'd0);
    send_op(2'b01, 4'd0, 5'd1,  5'd0, 5'd0, 20'h00FFF);
    send_op(2'b10, 4'd5, 5'd10, 5'd0, 5'd0, 20'h12345);
    send_op(2'b11, 4'd8, 5'd0,  5'd1, 5'd2, 20'h00008);
    wait_done("five");
    n_checks++;
    if (q_addr.size() != 5) $display("FAIL five_count: got %0d writes, required 5", q_addr.size());
    else n_pass++;
    for (int i = 0; i < 5 && i < q_addr.size(); i++) begin
      n_checks++;
      if (q_addr[i] !== 32'h1000 + 32'(4 * i) || q_data[i] !== exp_d[i])
        $display("FAIL five_word%0d: %h @%h, required %h @%h", i, q_data[i], q_addr[i], exp_d[i], 32'h1000 + 32'(4 * i));
      else n_pass++;
    end
  endtask

  task automatic test_illegal();
    q_addr.delete(); q_data.delete();
    do_start(32'h0000_2000, 8'd2);
    send_op(2'b00, 4'd0, 5'd3, 5'd1, 5'd2, 20'd0);
    send_op(2'b01, 4'd1, 5'd9, 5'd9, 5'd9, 20'd0);
    send_op(2'b00, 4'd1, 5'd5, 5'd6, 5'd7, 20'd0);
    wait_done("illegal");
    n_checks++;
    if (err_o !== 1'b1) $display("FAIL illegal_err: got %b, required 1", err_o);
    else n_pass++;
    n_checks++;
    if (q_addr.size() != 2 || q_data[0] !== 32'h002081B3 || q_data[1] !== 32'h407302B3 || q_addr[1] !== 32'h2004)
      $display("FAIL illegal_writes: %0d writes, required 2 (002081b3 @2000, 407302b3 @2004)", q_addr.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    q_addr.delete(); q_data.delete();
    mem_ready_i = 1'b0;
    do_start(32'h0000_3000, 8'd3);
    send_op(2'b00, 4'd7, 5'd4, 5'd5, 5'd6, 20'd0);
    send_op(2'b01, 4'd3, 5'd7, 5'd8, 5'd0, 20'hABC43);
    class_i = 2'b11; alu_op_i = 4'd9; rd_i = 5'd0; rs1_i = 5'd3; rs2_i = 5'd4; imm_i = 20'h01FFC;
    in_valid_i = 1'b1;
    #1;
    n_checks++;
    if (in_ready_o !== 1'b0) $display("FAIL bp_ready_full: got %b, required 0", in_ready_o);
    else n_pass++;
    tick(); tick();
    n_checks++;
    if ({mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b1, 32'h3000, 32'h0062C233})
      $display("FAIL bp_hold: we %b addr %h data %h, required 1 00003000 0062c233", mem_we_o, mem_addr_o, mem_wdata_o);
    else n_pass++;
    n_checks++;
    if (q_addr.size() != 0) $display("FAIL bp_no_write: got %0d writes, required 0", q_addr.size());
    else n_pass++;
    in_valid_i = 1'b0;
    mem_ready_i = 1'b1;
    send_op(2'b11, 4'd9, 5'd0, 5'd3, 5'd4, 20'h01FFC);
    wait_done("bp");
    n_checks++;
    if (q_addr.size() != 3 || q_data[0] !== 32'h0062C233 || q_data[1] !== 32'h00341393 ||
        q_data[2] !== 32'hFE419EE3 || q_addr[2] !== 32'h3008)
      $display("FAIL bp_order: %0d writes, required 3 (0062c233, 00341393, fe419ee3 @3000..3008)", q_addr.size());
    else n_pass++;
  endtask

  task automatic test_wrap();
    q_addr.delete(); q_data.delete();
    do_start(32'hFFFF_FFFC, 8'd2);
    send_op(2'b10, 4'd5, 5'd10, 5'd0, 5'd0, 20'h12345);
    send_op(2'b01, 4'd0, 5'd1,  5'd0, 5'd0, 20'h00FFF);
    wait_done("wrap");
    n_checks++;
    if (q_addr.size() != 2 || q_addr[0] !== 32'hFFFF_FFFC || q_addr[1] !== 32'h0 || q_data[1] !== 32'hFFF00093)
      $display("FAIL wrap_addr: %0d writes, required 2 @fffffffc then @00000000", q_addr.size());
    else n_pass++;
  endtask

  task automatic test_count_zero();
    q_addr.delete(); q_data.delete();
    do_start(32'h0000_5000, 8'd0);
    n_checks++;
    if ({done_o, busy_o, err_o, mem_we_o} !== 4'b0100)
      $display("FAIL cz_cycle1: done/busy/err/we %b, required 0100", {done_o, busy_o, err_o, mem_we_o});
    else n_pass++;
    tick();
    n_checks++;
    if ({done_o, busy_o, mem_we_o} !== 3'b100)
      $display("FAIL cz_cycle2: done/busy/we %b, required 100", {done_o, busy_o, mem_we_o});
    else n_pass++;
    tick();
    n_checks++;
    if ({done_o, q_addr.size() == 0} !== 2'b01)
      $display("FAIL cz_after: done %b writes %0d, required 0 and 0", done_o, q_addr.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int d0;
    q_addr.delete(); q_data.delete();
    mem_ready_i = 1'b0;
    do_start(32'h0000_6000, 8'd3);
    send_op(2'b00, 4'd6, 5'd1, 5'd2, 5'd3, 20'd0);
    n_checks++;
    if (mem_we_o !== 1'b1) $display("FAIL rm_buffered: mem_we_o %b, required 1", mem_we_o);
    else n_pass++;
    d0 = n_done;
    reset = 1'b0;
    tick();
    n_checks++;
    if ({mem_we_o, in_ready_o, busy_o, done_o, err_o, mem_addr_o, mem_wdata_o} !== 69'd0)
      $display("FAIL rm_outputs: we %b rdy %b busy %b done %b err %b addr %h data %h, required all 0",
               mem_we_o, in_ready_o, busy_o, done_o, err_o, mem_addr_o, mem_wdata_o);
    else n_pass++;
    reset = 1'b1;
    mem_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (n_done != d0 || q_addr.size() != 0 || mem_we_o !== 1'b0)
      $display("FAIL rm_abort: done pulses %0d writes %0d we %b, required 0 0 0", n_done - d0, q_addr.size(), mem_we_o);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b0; start_i = 1'b0; base_addr_i = '0; count_i = '0;
    in_valid_i = 1'b0; class_i = '0; alu_op_i = '0; rd_i = '0; rs1_i = '0; rs2_i = '0;
    imm_i = '0; mem_ready_i = 1'b1;
    #1;
    test_reset();
    test_single_add();
    test_five();
    test_illegal();
    test_count_zero();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
